// File: rtl/mms_seq_ctrl_pkg.sv
// Shared definitions for the serial min/max scheduler: FSM state encoding,
// select encoding and default build parameters.
package mms_seq_ctrl_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_COUNT  = 8;

  localparam logic SEL_MAX = 1'b0;
  localparam logic SEL_MIN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mms_seq_ctrl_cmp2.sv
// Combinational 2-input compare-select: returns b only when it strictly beats a
// in the selected direction, so ties always keep a.
module mms_seq_ctrl_cmp2
  import mms_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_sel,
  output logic [DATA_W-1:0] o_y
);

  logic w_take;

  assign w_take = (i_sel == SEL_MIN) ? (i_b < i_a) : (i_b > i_a);
  assign o_y    = w_take ? i_b : i_a;

endmodule

// File: rtl/mms_seq_ctrl.sv
// Serial min/max scheduler: accumulates a COUNT-long frame through one shared
// compare-select unit and returns the result on a valid/ready handshake.
module mms_seq_ctrl
  import mms_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COUNT  = DEF_COUNT,
  parameter int CNT_W  = $clog2(COUNT) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_select,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data,
  input  logic              i_out_ready,
  output logic              o_busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sel;
  logic [DATA_W-1:0] r_acc;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;
  logic [DATA_W-1:0] w_cmp_y;
  logic              w_accept;

  mms_seq_ctrl_cmp2 #(.DATA_W(DATA_W)) u_cmp2 (
    .i_a   (r_acc),
    .i_b   (i_in_data),
    .i_sel (r_sel),
    .o_y   (w_cmp_y)
  );

  assign w_accept = i_in_valid & r_in_ready;

  // Handshake flags are registered alongside the state so no input reaches an output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_sel       <= SEL_MAX;
      r_acc       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_sel      <= i_select;
            r_cnt      <= '0;
            r_state    <= ST_ACCUM;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            r_acc <= (r_cnt == '0) ? i_in_data : w_cmp_y;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST) begin
              r_state     <= ST_DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (i_out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_acc;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_mms_seq_ctrl.sv
// Directed bench for mms_seq_ctrl: a table of 8-value frames plus hand-written
// sequences for backpressure, ignored starts, mid-frame reset and a COUNT=1 build.
module tb_mms_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, select, inValid, outReady;
  logic [7:0] inData;
  logic       inReady, outValid, busy;
  logic [7:0] outData;

  logic       start1, select1, inValid1, outReady1;
  logic [7:0] inData1;
  logic       inReady1, outValid1, busy1;
  logic [7:0] outData1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       sel;
    logic [63:0] data;
    logic [7:0] gapMask;
    logic [7:0] expected;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  mms_seq_ctrl #(.DATA_W(8), .COUNT(8)) dut (
    .clk(clk), .reset(reset), .i_start(start), .i_select(select),
    .i_in_valid(inValid), .i_in_data(inData), .o_in_ready(inReady),
    .o_out_valid(outValid), .o_out_data(outData), .i_out_ready(outReady),
    .o_busy(busy)
  );

  mms_seq_ctrl #(.DATA_W(8), .COUNT(1)) dut1 (
    .clk(clk), .reset(reset), .i_start(start1), .i_select(select1),
    .i_in_valid(inValid1), .i_in_data(inData1), .o_in_ready(inReady1),
    .o_out_valid(outValid1), .o_out_data(outData1), .i_out_ready(outReady1),
    .o_busy(busy1)
  );

  function automatic logic [63:0] pack8(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
    return {b7, b6, b5, b4, b3, b2, b1, b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Runs one 8-value frame; gapMask bit i inserts two idle cycles after value i.
  task automatic applyStimulus(input vec_t v);
    int nTicks;
    int gaps;
    nTicks = 0;
    gaps = 0;
    start = 1'b1;
    select = v.sel;
    tick(); nTicks++;
    start = 1'b0;
    select = ~v.sel;
    checkOutput({v.name, " inReady after start"}, 32'(inReady), 32'd1);
    checkOutput({v.name, " busy after start"}, 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      inValid = 1'b1;
      inData = v.data[i*8 +: 8];
      tick(); nTicks++;
      inValid = 1'b0;
      if (i < 7) begin
        if (outValid !== 1'b0 || inReady !== 1'b1)
          checkOutput({v.name, " accum handshake"}, {30'd0, outValid, inReady}, 32'd1);
        if (v.gapMask[i]) begin
          gaps++;
          tick(); tick(); nTicks += 2;
          checkOutput({v.name, " inReady during gap"}, 32'(inReady), 32'd1);
        end
      end
    end
    checkOutput({v.name, " outValid latency"}, 32'(outValid), 32'd1);
    checkOutput({v.name, " start-to-outValid cycles"}, 32'(nTicks), 32'(9 + 2 * gaps));
    checkOutput({v.name, " result"}, 32'(outData), 32'(v.expected));
    checkOutput({v.name, " inReady in DONE"}, 32'(inReady), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 0; select = 0; inValid = 0; inData = 0; outReady = 0;
    start1 = 0; select1 = 0; inValid1 = 0; inData1 = 0; outReady1 = 0;

    vecs[0] = '{"max gapfree", 1'b0, pack8(3, 250, 17, 0, 99, 250, 128, 1), 8'h00, 8'd250};
    vecs[1] = '{"min gaps", 1'b1, pack8(40, 7, 255, 7, 12, 9, 200, 8), 8'b0010_0100, 8'd7};
    vecs[2] = '{"min allFF", 1'b1, pack8(255, 255, 255, 255, 255, 255, 255, 255), 8'h00, 8'd255};
    vecs[3] = '{"max allZero", 1'b0, pack8(0, 0, 0, 0, 0, 0, 0, 0), 8'h00, 8'd0};
    vecs[4] = '{"min descending", 1'b1, pack8(9, 8, 7, 6, 5, 4, 3, 2), 8'h00, 8'd2};
    vecs[5] = '{"max ties", 1'b0, pack8(17, 17, 16, 18, 18, 2, 1, 0), 8'h00, 8'd18};

    tick(); tick();
    reset = 1'b0;
    checkOutput("reset inReady", 32'(inReady), 32'd0);
    checkOutput("reset outValid", 32'(outValid), 32'd0);
    checkOutput("reset outData", 32'(outData), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);

    // Table frames back to back with outReady tied high: DONE lasts one cycle.
    outReady = 1'b1;
    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
      tick();
      checkOutput({vecs[k].name, " outValid drop"}, 32'(outValid), 32'd0);
      checkOutput({vecs[k].name, " busy drop"}, 32'(busy), 32'd0);
      checkOutput({vecs[k].name, " outData held in IDLE"}, 32'(outData), 32'(vecs[k].expected));
    end

    // Backpressure with start/select noise during ACCUM and DONE: mode stays max.
    outReady = 1'b0;
    start = 1'b1; select = 1'b0;
    tick();
    select = 1'b1;
    for (int i = 0; i < 8; i++) begin
      inValid = 1'b1;
      inData = 8'(10 + 7 * i);
      tick();
    end
    inValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("backpressure outValid", 32'(outValid), 32'd1);
      checkOutput("backpressure outData", 32'(outData), 32'd59);
      tick();
    end
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    start = 1'b0;
    tick();
    checkOutput("start in DONE ignored busy", 32'(busy), 32'd0);
    checkOutput("start in DONE ignored inReady", 32'(inReady), 32'd0);
    outReady = 1'b1;
    applyStimulus('{"fresh min", 1'b1, pack8(10, 17, 24, 31, 38, 45, 52, 59), 8'h00, 8'd10});
    tick();

    // Reset after the fourth accept discards the frame.
    start = 1'b1; select = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      inValid = 1'b1;
      inData = 8'(200 + i);
      tick();
    end
    inValid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midreset inReady", 32'(inReady), 32'd0);
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset outValid", 32'(outValid), 32'd0);
    tick();
    checkOutput("midreset no late outValid", 32'(outValid), 32'd0);
    applyStimulus('{"after reset max", 1'b0, pack8(1, 2, 3, 4, 5, 6, 7, 8), 8'h00, 8'd8});
    tick();

    // COUNT=1 build: the single accept goes straight to DONE.
    start1 = 1'b1; select1 = 1'b0;
    tick();
    start1 = 1'b0;
    checkOutput("count1 inReady", 32'(inReady1), 32'd1);
    checkOutput("count1 busy", 32'(busy1), 32'd1);
    inValid1 = 1'b1; inData1 = 8'd42;
    tick();
    inValid1 = 1'b0;
    checkOutput("count1 outValid", 32'(outValid1), 32'd1);
    checkOutput("count1 outData", 32'(outData1), 32'd42);
    checkOutput("count1 inReady in DONE", 32'(inReady1), 32'd0);
    outReady1 = 1'b1;
    tick();
    outReady1 = 1'b0;
    checkOutput("count1 outValid drop", 32'(outValid1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
